spi_escravo: RTL and testbench

//  - SPI slave (responder); pairs with spi_master on the same bus. Full-duplex, 8-bit frames, MSB first.
//  - Oversamples spi_clk, spi_cs_n and spi_mosi in the clk domain.
//  - Delivers each received byte on rx_dado/rx_valido and shifts out a byte supplied on tx_dado/tx_valido.

---
 rtl/spi_escravo_if.sv | 40 ++++
 rtl/spi_escravo.sv | 185 ++++++++++++++++++
 tb/tb_spi_escravo.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_escravo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : spi_escravo_if
// Brief     : Byte-side handshake and SPI pins of spi_escravo. The tx_underrun
//             signal exists only when SPI_ESCRAVO_UNDERRUN_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
interface spi_escravo_if;
    logic [7:0] tx_dado;
    logic       tx_valido;
    logic       tx_pronto;
    logic [7:0] rx_dado;
    logic       rx_valido;
    logic       spi_clk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
`ifdef SPI_ESCRAVO_UNDERRUN_EN
    logic       tx_underrun;
`endif

    modport slave (
        input  tx_dado, tx_valido, spi_clk, spi_cs_n, spi_mosi,
`ifdef SPI_ESCRAVO_UNDERRUN_EN
        output tx_underrun,
`endif
        output tx_pronto, rx_dado, rx_valido, spi_miso, spi_miso_oe
    );

    modport master (
        output tx_dado, tx_valido, spi_clk, spi_cs_n, spi_mosi,
`ifdef SPI_ESCRAVO_UNDERRUN_EN
        input  tx_underrun,
`endif
        input  tx_pronto, rx_dado, rx_valido, spi_miso, spi_miso_oe
    );
endinterface
`default_nettype wire

// File: rtl/spi_escravo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_escravo
// Brief    : SPI slave, 8-bit full-duplex frames, MSB first, with all SPI
//            inputs oversampled in clk. Define SPI_ESCRAVO_UNDERRUN_EN to get
//            the tx_underrun pulse output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_escravo #(
    parameter int         MODO_SPI      = 0,
    parameter int         ESTAGIOS_SYNC = 2,
    parameter logic [7:0] DADO_OCIOSO   = 8'h00
) (
    input  wire logic     clk,
    input  wire logic     rst,
    spi_escravo_if.slave  bus
);
    localparam logic c_cpol = MODO_SPI[1];
    localparam logic c_cpha = MODO_SPI[0];

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ATIVO  = 1'b1
    } estado_t;

    estado_t                  r_state, w_state_nxt;
    logic [ESTAGIOS_SYNC-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                     r_sclk_prev;
    logic [2:0]               r_bit_cnt;
    logic [6:0]               r_rx_shift;
    logic [7:0]               r_rx_dado;
    logic                     r_rx_valido;
    logic [7:0]               r_tx_shift;
    logic                     r_miso;
    logic                     r_miso_oe;
    logic [7:0]               r_hold;
    logic                     r_hold_full;

    logic       w_sclk, w_cs, w_mosi;
    logic       w_lead, w_trail, w_sample, w_shift;
    logic       w_enter, w_exit;
    logic       w_smp_act, w_shf_act, w_byte_done, w_take, w_load;
    logic [7:0] w_next_byte;

    assign w_sclk  = r_sclk_sync[ESTAGIOS_SYNC-1];
    assign w_cs    = r_cs_sync[ESTAGIOS_SYNC-1];
    assign w_mosi  = r_mosi_sync[ESTAGIOS_SYNC-1];

    assign w_lead   = (r_sclk_prev == c_cpol) && (w_sclk != c_cpol);
    assign w_trail  = (r_sclk_prev != c_cpol) && (w_sclk == c_cpol);
    assign w_sample = c_cpha ? w_trail : w_lead;
    assign w_shift  = c_cpha ? w_lead  : w_trail;

    assign w_smp_act   = (r_state == ATIVO) && w_sample;
    assign w_shf_act   = (r_state == ATIVO) && w_shift && !w_cs;
    assign w_byte_done = w_smp_act && (r_bit_cnt == 3'd7);
    // A new byte starts on selection and at every byte boundary while still
    // selected; for CPHA=0 the boundary is the trailing edge closing the byte.
    assign w_take      = w_enter ||
                         (c_cpha ? (w_byte_done && !w_cs)
                                 : (w_shf_act && (r_bit_cnt == 3'd0)));
    assign w_load      = bus.tx_valido && !r_hold_full;
    assign w_next_byte = r_hold_full ? r_hold : DADO_OCIOSO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= {ESTAGIOS_SYNC{c_cpol}};
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= c_cpol;
        end else begin
            r_sclk_sync <= {r_sclk_sync[ESTAGIOS_SYNC-2:0], bus.spi_clk};
            r_cs_sync   <= {r_cs_sync[ESTAGIOS_SYNC-2:0], bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[ESTAGIOS_SYNC-2:0], bus.spi_mosi};
            r_sclk_prev <= w_sclk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (!w_cs) begin
                    w_state_nxt = ATIVO;
                    w_enter     = 1'b1;
                end
            end
            ATIVO: begin
                if (w_cs) begin
                    w_state_nxt = OCIOSO;
                    w_exit      = 1'b1;
                end
            end
            default: w_state_nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OCIOSO;
            r_bit_cnt   <= 3'd0;
            r_rx_shift  <= 7'd0;
            r_rx_dado   <= 8'h00;
            r_rx_valido <= 1'b0;
            r_tx_shift  <= 8'h00;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_valido <= 1'b0;

            // A same-cycle load never feeds the reload: w_next_byte uses the old value.
            if (w_load) begin
                r_hold      <= bus.tx_dado;
                r_hold_full <= 1'b1;
            end else if (w_take) begin
                r_hold_full <= 1'b0;
            end

            if (w_enter) begin
                r_bit_cnt  <= 3'd0;
                r_tx_shift <= w_next_byte;
                r_miso_oe  <= 1'b1;
                r_miso     <= c_cpha ? 1'b0 : w_next_byte[7];
            end

            if (w_smp_act) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_dado   <= {r_rx_shift, w_mosi};
                    r_rx_valido <= 1'b1;
                end
                if (c_cpha && w_byte_done && !w_cs)
                    r_tx_shift <= w_next_byte;
            end

            if (w_shf_act) begin
                if (c_cpha) begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end else if (r_bit_cnt == 3'd0) begin
                    r_tx_shift <= w_next_byte;
                    r_miso     <= w_next_byte[7];
                end else begin
                    r_miso     <= r_tx_shift[6];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
            end

            if (w_exit) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end
        end
    end

    assign bus.tx_pronto   = !r_hold_full;
    assign bus.rx_dado     = r_rx_dado;
    assign bus.rx_valido   = r_rx_valido;
    assign bus.spi_miso    = r_miso;
    assign bus.spi_miso_oe = r_miso_oe;

`ifdef SPI_ESCRAVO_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_underrun <= 1'b0;
        else
            r_underrun <= w_take && !r_hold_full;
    end

    assign bus.tx_underrun = r_underrun;
`else
    // Underrun stays silent; w_next_byte still falls back to DADO_OCIOSO.
`endif
endmodule
`default_nettype wire

// File: tb/tb_spi_escravo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_escravo
// Brief    : Self-checking bench for spi_escravo in modes 0 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_escravo;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_sclk = 1'b0;
    logic       m_mosi = 1'b0;
    logic [1:0] m_cs_n = 2'b11;

    always #5 clk = ~clk;

    spi_escravo_if bus0 ();
    spi_escravo_if bus3 ();

    assign bus0.spi_clk  = m_sclk;
    assign bus0.spi_cs_n = m_cs_n[0];
    assign bus0.spi_mosi = m_mosi;
    assign bus3.spi_clk  = m_sclk;
    assign bus3.spi_cs_n = m_cs_n[1];
    assign bus3.spi_mosi = m_mosi;

    spi_escravo #(.MODO_SPI(0), .ESTAGIOS_SYNC(2), .DADO_OCIOSO(8'h00)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    spi_escravo #(.MODO_SPI(3), .ESTAGIOS_SYNC(2), .DADO_OCIOSO(8'h00)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int checks   = 0;
    int failures = 0;

    // Received-byte logs and underrun pulse counts per slave.
    logic [7:0] q0[$];
    logic [7:0] q3[$];
    int         un0 = 0;
    int         un3 = 0;
    int         un_snap = 0;

    always @(negedge clk) begin
        if (bus0.rx_valido === 1'b1) q0.push_back(bus0.rx_dado);
        if (bus3.rx_valido === 1'b1) q3.push_back(bus3.rx_dado);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
        if (bus0.tx_underrun === 1'b1) un0++;
        if (bus3.tx_underrun === 1'b1) un3++;
`endif
    end

    // Master-side transfer description: bytes sent and bytes supplied mid-burst.
    logic [7:0] m_tx[4];
    logic [7:0] m_rx[4];
    logic [7:0] m_val[4];
    bit         m_sup[4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic miso_of(input bit s);
        return s ? bus3.spi_miso : bus0.spi_miso;
    endfunction

    function automatic logic pronto_of(input bit s);
        return s ? bus3.tx_pronto : bus0.tx_pronto;
    endfunction

    task automatic check_reset_outputs(input string tag, input bit s);
        if (s) begin
            chk($sformatf("%s_tx_pronto", tag), bus3.tx_pronto, 1);
            chk($sformatf("%s_rx_dado", tag), bus3.rx_dado, 8'h00);
            chk($sformatf("%s_rx_valido", tag), bus3.rx_valido, 0);
            chk($sformatf("%s_miso", tag), bus3.spi_miso, 0);
            chk($sformatf("%s_miso_oe", tag), bus3.spi_miso_oe, 0);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
            chk($sformatf("%s_underrun", tag), bus3.tx_underrun, 0);
`endif
        end else begin
            chk($sformatf("%s_tx_pronto", tag), bus0.tx_pronto, 1);
            chk($sformatf("%s_rx_dado", tag), bus0.rx_dado, 8'h00);
            chk($sformatf("%s_rx_valido", tag), bus0.rx_valido, 0);
            chk($sformatf("%s_miso", tag), bus0.spi_miso, 0);
            chk($sformatf("%s_miso_oe", tag), bus0.spi_miso_oe, 0);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
            chk($sformatf("%s_underrun", tag), bus0.tx_underrun, 0);
`endif
        end
    endtask

    task automatic load(input bit s, input logic [7:0] v);
        chk("tx_pronto_before_load", pronto_of(s), 1);
        if (s) begin bus3.tx_dado = v; bus3.tx_valido = 1'b1; end
        else   begin bus0.tx_dado = v; bus0.tx_valido = 1'b1; end
        tick(1);
        bus0.tx_valido = 1'b0;
        bus3.tx_valido = 1'b0;
        chk("tx_pronto_after_load", pronto_of(s), 0);
    endtask

    // Bit-level master. s=0 -> mode 0, s=1 -> mode 3. stop_bit>=0 ends the
    // frame early, either by raising cs_n or (do_rst) by pulsing rst.
    task automatic xfer(input bit s, input int n, input int stop_bit, input bit do_rst);
        bit mono_ok = 1'b1;
        m_sclk = s;
        tick(2);
        for (int i = 0; i < 4; i++) m_rx[i] = 8'h00;
        m_cs_n[s] = 1'b0;
        m_mosi    = m_tx[0][7];
        tick(HP);
        for (int b = 0; b < n * 8; b++) begin
            int i = b / 8;
            int k = 7 - (b % 8);
            if (b == stop_bit) begin
                if (do_rst) begin
                    rst = 1'b1;
                    tick(2);
                    check_reset_outputs("rst_mid", s);
                    m_cs_n[s] = 1'b1;
                    m_sclk    = s;
                    tick(2);
                    rst = 1'b0;
                    tick(2);
                end else begin
                    m_cs_n[s] = 1'b1;
                    m_sclk    = s;
                    tick(HP);
                    chk("abort_miso_oe", s ? bus3.spi_miso_oe : bus0.spi_miso_oe, 0);
                    tick(HP);
                end
                return;
            end
            if (!s) begin
                m_rx[i][k] = miso_of(s);
                m_sclk = 1'b1;
                if (b % 8 == 0 && i + 1 < n && m_sup[i+1]) begin load(s, m_val[i+1]); tick(HP - 1); end
                else tick(HP);
                if (b == n * 8 - 1) un_snap = un0;
                m_sclk = 1'b0;
                if (b + 1 < n * 8) m_mosi = m_tx[(b+1)/8][7 - ((b+1) % 8)];
                tick(HP);
            end else begin
                m_sclk = 1'b0;
                m_mosi = m_tx[i][k];
                if (b % 8 == 0 && i + 1 < n && m_sup[i+1]) begin load(s, m_val[i+1]); tick(HP - 1); end
                else tick(HP);
                m_rx[i][k] = miso_of(s);
                if (b == n * 8 - 1) un_snap = un3;
                m_sclk = 1'b1;
                tick(HP - 1);
                if (miso_of(s) !== m_rx[i][k]) mono_ok = 1'b0;
                tick(1);
            end
        end
        m_cs_n[s] = 1'b1;
        m_sclk    = s;
        m_mosi    = 1'b0;
        tick(2 * HP);
        if (s) chk("mode3_miso_only_on_falling", mono_ok, 1);
    endtask

    // Reference: each byte the slave returns is the holding value loaded
    // before that byte began, else DADO_OCIOSO; every completed byte appears
    // once on rx_dado.
    task automatic do_xfer(input string tag, input bit s, input int n, input bit pre, input logic [7:0] pv);
        int base = s ? q3.size() : q0.size();
        int got;
        logic [7:0] exp_tx;
        if (pre) load(s, pv);
        xfer(s, n, -1, 1'b0);
        got = (s ? q3.size() : q0.size()) - base;
        chk($sformatf("%s_rx_valido_count", tag), got, n);
        for (int i = 0; i < n; i++) begin
            exp_tx = (i == 0) ? (pre ? pv : 8'h00) : (m_sup[i] ? m_val[i] : 8'h00);
            chk($sformatf("%s_master_rx%0d", tag, i), m_rx[i], exp_tx);
            if (i < got)
                chk($sformatf("%s_rx_dado%0d", tag, i), s ? q3[base+i] : q0[base+i], m_tx[i]);
        end
        chk($sformatf("%s_final_rx_dado", tag), s ? bus3.rx_dado : bus0.rx_dado, m_tx[n-1]);
        chk($sformatf("%s_tx_pronto_idle", tag), pronto_of(s), 1);
        for (int i = 0; i < 4; i++) m_sup[i] = 1'b0;
    endtask

    initial begin
        int base;
        int un_base;
        bit s;
        int n;
        bit pre;
        logic [7:0] pv;

        bus0.tx_dado = 8'h00; bus0.tx_valido = 1'b0;
        bus3.tx_dado = 8'h00; bus3.tx_valido = 1'b0;
        for (int i = 0; i < 4; i++) begin m_sup[i] = 1'b0; m_val[i] = 8'h00; m_tx[i] = 8'h00; end
        tick(3);
        rst = 1'b0;
        tick(2);
        check_reset_outputs("reset0", 1'b0);
        check_reset_outputs("reset3", 1'b1);

        m_tx[0] = 8'hA5;
        do_xfer("mode0", 1'b0, 1, 1'b1, 8'h3C);

        m_tx[0] = 8'h7E;
        do_xfer("mode3", 1'b1, 1, 1'b1, 8'h81);

        m_tx[0] = 8'hF0; m_tx[1] = 8'h0F;
        m_sup[1] = 1'b1; m_val[1] = 8'h22;
        do_xfer("b2b", 1'b0, 2, 1'b1, 8'h11);

        base = q0.size();
        m_tx[0] = 8'($urandom);
        xfer(1'b0, 1, 3, 1'b0);
        chk("abort_no_rx_valido", q0.size() - base, 0);
        m_tx[0] = 8'hC3;
        do_xfer("after_abort", 1'b0, 1, 1'b0, 8'h00);

        un_base = un0;
        m_tx[0] = 8'($urandom);
        do_xfer("underrun", 1'b0, 1, 1'b0, 8'h00);
`ifdef SPI_ESCRAVO_UNDERRUN_EN
        chk("underrun_pulses_at_byte_start", un_snap - un_base, 1);
`endif

        base = q0.size();
        m_tx[0] = 8'($urandom);
        load(1'b0, 8'($urandom));
        xfer(1'b0, 1, 5, 1'b1);
        chk("rst_no_rx_valido", q0.size() - base, 0);
        check_reset_outputs("post_rst", 1'b0);
        m_tx[0] = 8'h5A;
        do_xfer("after_rst", 1'b0, 1, 1'b1, 8'($urandom));

        for (int it = 0; it < 8; it++) begin
            s   = 1'($urandom_range(1, 0));
            n   = $urandom_range(3, 1);
            pre = 1'($urandom_range(1, 0));
            pv  = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                m_tx[i]  = 8'($urandom);
                m_val[i] = 8'($urandom);
                m_sup[i] = (i > 0) && ($urandom_range(1, 0) == 1);
            end
            do_xfer($sformatf("rand%0d", it), s, n, pre, pv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
